// File: rtl/nes_cpu_bus_master.sv
// NES CPU-side bus-cycle initiator: turns valid/ready read/write requests into
// M2 bus cycles (LO setup, HI strobe, one-clk HOLD) and free-runs idle cycles otherwise.
module nes_cpu_bus_master #(
    parameter int M2_LO = 3,
    parameter int M2_HI = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdat,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdat,
    output logic        m2,
    output logic [15:0] cpu_addr,
    output logic        cpu_rw,
    output logic        cpu_ce,
    output logic [7:0]  cpu_dat_o,
    output logic        cpu_dat_oe,
    input  logic [7:0]  cpu_dat_i,
    output logic [15:0] wr_cnt
);

    localparam int MAXP = (M2_LO > M2_HI) ? M2_LO : M2_HI;
    localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;
    localparam logic [CW-1:0] LO_LAST = CW'(M2_LO - 1);
    localparam logic [CW-1:0] HI_LAST = CW'(M2_HI - 1);

    typedef enum logic [1:0] {
        ST_LO,
        ST_HI,
        ST_HOLD
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic          act_reg;
    logic          we_reg;
    logic [15:0]   addr_reg;
    logic [7:0]    wdat_reg;
    logic [7:0]    rdat_reg;
    logic [15:0]   wr_cnt_reg;

    logic          accept;
    logic          last_hi;
    logic          strobe;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_LO;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        m2         = 1'b0;
        last_hi    = 1'b0;
        strobe     = 1'b0;
        case (state_reg)
            ST_LO: begin
                if (cnt_reg == LO_LAST) begin
                    state_next = ST_HI;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_HI: begin
                m2     = 1'b1;
                strobe = 1'b1;
                if (cnt_reg == HI_LAST) begin
                    last_hi    = 1'b1;
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_HOLD: begin
                // Strobe stays asserted through HOLD so latches see it at M2 fall.
                strobe     = 1'b1;
                req_ready  = 1'b1;
                state_next = ST_LO;
                cnt_next   = '0;
            end
            default: begin
                state_next = ST_LO;
                cnt_next   = '0;
            end
        endcase
    end

    assign accept     = req_ready && req_valid;

    assign cpu_addr   = addr_reg;
    assign cpu_rw     = !(act_reg && we_reg);
    assign cpu_ce     = !(act_reg && addr_reg[15] && strobe);
    assign cpu_dat_o  = wdat_reg;
    assign cpu_dat_oe = act_reg && we_reg;
    assign rsp_valid  = (state_reg == ST_HOLD) && act_reg && !we_reg;
    assign rsp_rdat   = rdat_reg;
    assign wr_cnt     = wr_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_reg    <= 1'b0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdat_reg   <= '0;
            rdat_reg   <= '0;
            wr_cnt_reg <= '0;
        end else begin
            if (accept) begin
                act_reg  <= 1'b1;
                we_reg   <= req_we;
                addr_reg <= req_addr;
                wdat_reg <= req_wdat;
            end else if (state_reg == ST_HOLD) begin
                // Idle cycle: address bus keeps its last value.
                act_reg <= 1'b0;
                we_reg  <= 1'b0;
            end
            if (last_hi && act_reg && !we_reg) begin
                rdat_reg <= cpu_dat_i;
            end
            if ((state_reg == ST_HOLD) && act_reg && we_reg) begin
                wr_cnt_reg <= wr_cnt_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_nes_cpu_bus_master.sv
// Self-checking bench for nes_cpu_bus_master: per-clk reference built from the bus-cycle
// position (n mod 7) and the request accepted at the previous HOLD, plus a mapper-58 latch.
module tb_nes_cpu_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdat;
    logic        rsp_valid;
    logic [7:0]  rsp_rdat;
    logic        m2;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic        cpu_ce;
    logic [7:0]  cpu_dat_o;
    logic        cpu_dat_oe;
    logic [7:0]  cpu_dat_i;
    logic [15:0] wr_cnt;

    always #5 clk = ~clk;

    nes_cpu_bus_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdat   (req_wdat),
        .rsp_valid  (rsp_valid),
        .rsp_rdat   (rsp_rdat),
        .m2         (m2),
        .cpu_addr   (cpu_addr),
        .cpu_rw     (cpu_rw),
        .cpu_ce     (cpu_ce),
        .cpu_dat_o  (cpu_dat_o),
        .cpu_dat_oe (cpu_dat_oe),
        .cpu_dat_i  (cpu_dat_i),
        .wr_cnt     (wr_cnt)
    );

    // Mapper-58 register model: latches address bits on falling M2 of a $8000+ write.
    logic [2:0] prg = 3'd0;
    logic [2:0] chr = 3'd0;
    logic       prg_mode = 1'b0;
    logic       mirror = 1'b0;

    always @(negedge m2) begin
        if (!cpu_ce && !cpu_rw) begin
            prg      <= cpu_addr[2:0];
            chr      <= cpu_addr[5:3];
            prg_mode <= cpu_addr[6];
            mirror   <= cpu_addr[7];
        end
    end

    int total = 0;
    int bad = 0;
    int n = 0;
    bit armed = 1'b0;
    bit hold_dat = 1'b0;

    // Reference: the request (if any) that defines the current bus cycle.
    bit          m_act = 1'b0;
    bit          m_we = 1'b0;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wdat = '0;
    logic [7:0]  m_rdat = '0;
    logic [15:0] m_wr = '0;
    logic [15:0] w0;
    logic [2:0]  e_prg = 3'd0;
    logic [2:0]  e_chr = 3'd0;
    logic        e_pm = 1'b0;
    logic        e_mir = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic step();
        int p;
        p = n % 7;
        @(negedge clk);
        if (armed) begin
            chk("m2", 32'(m2), 32'(p >= 3 && p <= 5));
            chk("req_ready", 32'(req_ready), 32'(p == 6));
            chk("cpu_addr", 32'(cpu_addr), 32'(m_addr));
            chk("cpu_rw", 32'(cpu_rw), 32'(!(m_act && m_we)));
            chk("cpu_ce", 32'(cpu_ce), 32'(!(m_act && m_addr[15] && p >= 3)));
            chk("cpu_dat_oe", 32'(cpu_dat_oe), 32'(m_act && m_we));
            if (m_act && m_we) chk("cpu_dat_o", 32'(cpu_dat_o), 32'(m_wdat));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_act && !m_we && p == 6));
            chk("rsp_rdat", 32'(rsp_rdat), 32'(m_rdat));
            chk("wr_cnt", 32'(wr_cnt), 32'(m_wr));
        end
        if (!rst_n) begin
            n = 0; m_act = 0; m_we = 0; m_addr = '0; m_wdat = '0; m_rdat = '0; m_wr = '0;
            armed = 1'b1;
        end else begin
            if (p == 5 && m_act && !m_we) m_rdat = cpu_dat_i;
            if (p == 6) begin
                if (m_act && m_we) m_wr = m_wr + 16'd1;
                if (req_valid) begin
                    m_act = 1; m_we = req_we; m_addr = req_addr; m_wdat = req_wdat;
                end else begin
                    m_act = 0;
                end
            end
            n++;
        end
        @(posedge clk);
        #1;
        if (!hold_dat) cpu_dat_i = 8'($urandom);
    endtask

    task automatic to_hold();
        for (int i = 0; i < 7 && (n % 7) != 6; i++) step();
    endtask

    task automatic check_mapper(input string tag);
        chk({tag, "_prg"}, 32'(prg), 32'(e_prg));
        chk({tag, "_chr"}, 32'(chr), 32'(e_chr));
        chk({tag, "_prg_mode"}, 32'(prg_mode), 32'(e_pm));
        chk({tag, "_mirror"}, 32'(mirror), 32'(e_mir));
    endtask

    task automatic expect_map(input logic we, input logic [15:0] a);
        if (we && a[15]) begin
            e_prg = a[2:0]; e_chr = a[5:3]; e_pm = a[6]; e_mir = a[7];
        end
    endtask

    // One complete request: accept at HOLD, scramble req_* afterwards, run the cycle out.
    task automatic txn(input logic we, input logic [15:0] a, input logic [7:0] d);
        to_hold();
        req_we = we; req_addr = a; req_wdat = d; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = 16'($urandom); req_wdat = 8'($urandom);
        repeat (7) step();
        expect_map(we, a);
        check_mapper("map");
        $display("txn we=%0d addr=%h wdat=%h rdat=%h wr_cnt=%0d", we, a, d, rsp_rdat, wr_cnt);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdat = '0;
        cpu_dat_i = 8'h00;
        repeat (3) step();
        chk("rst_m2", 32'(m2), 32'd0);
        chk("rst_rw", 32'(cpu_rw), 32'd1);
        chk("rst_ce", 32'(cpu_ce), 32'd1);
        chk("rst_addr", 32'(cpu_addr), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        rst_n = 1'b1;
        repeat (14) step();

        txn(1'b1, 16'h80C5, 8'h00);
        chk("w80c5_prg5", 32'(prg), 32'd5);
        chk("w80c5_mir", 32'(mirror), 32'd1);

        w0 = m_wr;
        txn(1'b1, 16'h6000, 8'hAB);
        chk("w6000_cnt", 32'(wr_cnt), 32'(w0 + 16'd1));

        hold_dat = 1'b1; cpu_dat_i = 8'h5A;
        w0 = m_wr;
        txn(1'b0, 16'hC123, 8'h00);
        hold_dat = 1'b0;
        chk("rd_c123_dat", 32'(rsp_rdat), 32'h5A);
        chk("rd_c123_cnt", 32'(wr_cnt), 32'(w0));

        // Three writes with req_valid held high across HOLDs.
        w0 = m_wr;
        to_hold();
        for (int i = 0; i < 3; i++) begin
            req_we = 1'b1;
            req_addr = (i == 0) ? 16'h8001 : (i == 1) ? 16'h8012 : 16'hFFFF;
            req_wdat = 8'(i);
            req_valid = 1'b1;
            step();
            if (i < 2) repeat (6) step();
        end
        req_valid = 1'b0;
        repeat (7) step();
        expect_map(1'b1, 16'hFFFF);
        check_mapper("b2b");
        chk("b2b_cnt", 32'(wr_cnt), 32'(w0 + 16'd3));

        for (int k = 0; k < 40; k++) begin
            repeat (7 * $urandom_range(0, 2)) step();
            txn(1'($urandom), 16'($urandom), 8'($urandom));
        end

        // Reset asserted in the HI phase of a write.
        to_hold();
        req_we = 1'b1; req_addr = 16'h8033; req_wdat = 8'h77; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        chk("abort_m2", 32'(m2), 32'd0);
        chk("abort_ce", 32'(cpu_ce), 32'd1);
        chk("abort_rw", 32'(cpu_rw), 32'd1);
        chk("abort_oe", 32'(cpu_dat_oe), 32'd0);
        chk("abort_cnt", 32'(wr_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (14) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
